id_ex_stage: RTL and testbench
==============================

# id_ex_stage

Decode-to-execute pipeline stage of the five-stage RISC-V core. It registers the decoded control bundle (result_src, mem_write, branch, alu_src, reg_write, jump, alu_control) and the decode datapath fields into the EX stage. It also generates the stage-local hazard signals: the load-use stall, the taken-branch/jump flush and the EX operand forwarding selects. It sits between the decode stage, which feeds it the control decoder outputs and register-file reads, and the ALU/branch logic in EX.

## Interface
Parameters:
- XLEN, 32, datapath width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- d_result_src  in  2  decode result select (01 = load).
- d_mem_write, d_branch, d_alu_src, d_reg_write, d_jump  in  1 each  decode control bits.
- d_alu_control  in  3  decode ALU operation.
- d_rd1, d_rd2, d_pc, d_pc_plus4, d_imm_ext  in  XLEN each  decode datapath fields.
- d_rs1, d_rs2, d_rd  in  5 each  decode register indices.
- e_pc_src  in  1  EX branch taken or jump (redirect).
- m_rd, w_rd  in  5 each  destination register in MEM and in WB.
- m_reg_write, w_reg_write  in  1 each  MEM/WB write enables.
- e_result_src, e_mem_write, e_branch, e_alu_src, e_reg_write, e_jump, e_alu_control  out  same widths as d_*  registered control.
- e_rd1, e_rd2, e_pc, e_pc_plus4, e_imm_ext, e_rs1, e_rs2, e_rd  out  same widths as d_*  registered datapath fields.
- e_valid  out  1  EX holds a real instruction (0 = bubble).
- stall_f, stall_d  out  1  hold PC / hold IF-ID register.
- flush_d  out  1  clear IF-ID register.
- forward_a_e, forward_b_e  out  2  EX operand select: 00 = register file, 01 = WB result, 10 = MEM ALU result.

## Operation
- Normal cycle: every d_* field loads into its e_* register and e_valid goes to 1.
- Bubble insert, one cycle:
  - Triggered by flush_e = lw_stall | e_pc_src.
  - e_valid, e_reg_write, e_mem_write, e_branch and e_jump are set to 0.
  - Every other e_* field is also cleared to 0.
- Load-use stall:
  - lw_stall = e_valid & (e_result_src == 01) & (e_rd != 0) & (e_rd == d_rs1 | e_rd == d_rs2).
  - d_rs1 and d_rs2 are compared unconditionally. This is conservative and accepted.
- stall_f = stall_d = lw_stall. flush_d = e_pc_src.
- e_pc_src and lw_stall are architecturally exclusive, because a load never redirects. If both are asserted, the flush takes priority: stall_f = stall_d = 0, flush_d = 1, and a bubble is inserted.
- Forwarding for operand A:
  - forward_a_e = 10 if m_reg_write & m_rd != 0 & m_rd == e_rs1.
  - Otherwise 01 if w_reg_write & w_rd != 0 & w_rd == e_rs1.
  - Otherwise 00.
  - MEM has priority over WB.
- Forwarding for operand B: same rules, using e_rs2.
- x0 is never forwarded and never causes a stall.

## Timing
- D to E latency: 1 cycle.
- stall_f, stall_d, flush_d and forward_*_e are combinational from the current e_* registers and the inputs.
- Reset (rst_n = 0 at an edge):
  - All e_* registers and e_valid go to 0.
  - While rst_n = 0, the combinational outputs are forced to 0 / 00.
- Reset mid-stall drops the stall at once. The decode instruction is re-presented by upstream after reset.
- A load-use stall lasts exactly 1 cycle: the bubble clears e_result_src, so lw_stall deasserts on the next cycle.
- A redirect produces exactly 1 bubble in EX and 1 flush of decode.

## Configuration
- FORWARDING_EN defined: forwarding and load-use stall exactly as described above.
- FORWARDING_EN undefined:
  - forward_a_e and forward_b_e are tied to 00.
  - lw_stall is replaced by raw_stall, which asserts on any match of d_rs1 or d_rs2 (nonzero) against either source:
    - e_rd, when e_valid & e_reg_write;
    - m_rd, when m_reg_write.
  - WB needs no stall, because the register file writes in the first half-cycle.
  - Bubble insertion is identical. A dependent instruction stalls for up to 2 cycles.

## Test plan
- Reset: hold rst_n = 0 for 2 cycles with all d_* = 1s -> all e_* = 0, e_valid = 0, stall/flush = 0, forwards = 00.
- Pass-through: d_pc = 0x100, d_reg_write = 1, d_alu_control = 010 -> next cycle e_pc = 0x100, e_reg_write = 1, e_alu_control = 010, e_valid = 1.
- Load-use: lw x5 in EX, then add x6, x5, x1 in decode -> stall_f = stall_d = 1 for 1 cycle; next cycle e_valid = 0, e_reg_write = 0; the add enters EX one cycle later, with forward_a_e = 01 when the lw reaches WB.
- Forward priority: e_rs1 = 7, m_rd = 7 with m_reg_write = 1, w_rd = 7 with w_reg_write = 1 -> forward_a_e = 10. Same case with m_rd = 0 and w_rd = 0 -> 00.
- Redirect: e_pc_src = 1 -> flush_d = 1 same cycle; next cycle e_valid = 0 and e_mem_write = 0. Assert a simultaneous forced lw_stall -> stall_f = 0, flush_d = 1.
- FORWARDING_EN undefined: add x3 in EX, then sub x4, x3, x2 in decode -> stall_d = 1 for 2 cycles, forwards stay 00, the sub reaches EX on the 3rd cycle.

Source files
------------

// File: rtl/id_ex_stage.sv
// id_ex_stage: decode-to-execute pipeline register of the five-stage RISC-V core.
// Registers the decoded control bundle and datapath fields into EX, and derives
// the stage-local hazard controls (decode stall, decode flush, EX forwarding selects).
// Optional feature macro: FORWARDING_EN
//   defined   -> MEM/WB forwarding into EX plus a one-cycle load-use stall
//   undefined -> forwards tied to 00, decode stalls on any RAW hit against EX or MEM
module id_ex_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      d_result_src,
    input  logic            d_mem_write,
    input  logic            d_branch,
    input  logic            d_alu_src,
    input  logic            d_reg_write,
    input  logic            d_jump,
    input  logic [2:0]      d_alu_control,
    input  logic [XLEN-1:0] d_rd1,
    input  logic [XLEN-1:0] d_rd2,
    input  logic [XLEN-1:0] d_pc,
    input  logic [XLEN-1:0] d_pc_plus4,
    input  logic [XLEN-1:0] d_imm_ext,
    input  logic [4:0]      d_rs1,
    input  logic [4:0]      d_rs2,
    input  logic [4:0]      d_rd,
    input  logic            e_pc_src,
    input  logic [4:0]      m_rd,
    input  logic [4:0]      w_rd,
    input  logic            m_reg_write,
    input  logic            w_reg_write,
    output logic [1:0]      e_result_src,
    output logic            e_mem_write,
    output logic            e_branch,
    output logic            e_alu_src,
    output logic            e_reg_write,
    output logic            e_jump,
    output logic [2:0]      e_alu_control,
    output logic [XLEN-1:0] e_rd1,
    output logic [XLEN-1:0] e_rd2,
    output logic [XLEN-1:0] e_pc,
    output logic [XLEN-1:0] e_pc_plus4,
    output logic [XLEN-1:0] e_imm_ext,
    output logic [4:0]      e_rs1,
    output logic [4:0]      e_rs2,
    output logic [4:0]      e_rd,
    output logic            e_valid,
    output logic            stall_f,
    output logic            stall_d,
    output logic            flush_d,
    output logic [1:0]      forward_a_e,
    output logic [1:0]      forward_b_e
);

    logic [1:0]      r_eResultSrc;
    logic            r_eMemWrite;
    logic            r_eBranch;
    logic            r_eAluSrc;
    logic            r_eRegWrite;
    logic            r_eJump;
    logic [2:0]      r_eAluControl;
    logic [XLEN-1:0] r_eRd1;
    logic [XLEN-1:0] r_eRd2;
    logic [XLEN-1:0] r_ePc;
    logic [XLEN-1:0] r_ePcPlus4;
    logic [XLEN-1:0] r_eImmExt;
    logic [4:0]      r_eRs1;
    logic [4:0]      r_eRs2;
    logic [4:0]      r_eRd;
    logic            r_eValid;

    logic            w_hazardStall;
    logic            w_flushE;
    logic [1:0]      w_fwdA;
    logic [1:0]      w_fwdB;

`ifdef FORWARDING_EN
    // Load-use detection on the instruction in EX, and MEM-over-WB forwarding selects
    always_comb begin
        w_hazardStall = r_eValid && (r_eResultSrc == 2'b01) && (r_eRd != 5'd0) &&
                        ((r_eRd == d_rs1) || (r_eRd == d_rs2));
        w_fwdA = 2'b00;
        if (m_reg_write && (m_rd != 5'd0) && (m_rd == r_eRs1)) begin
            w_fwdA = 2'b10;
        end else if (w_reg_write && (w_rd != 5'd0) && (w_rd == r_eRs1)) begin
            w_fwdA = 2'b01;
        end
        w_fwdB = 2'b00;
        if (m_reg_write && (m_rd != 5'd0) && (m_rd == r_eRs2)) begin
            w_fwdB = 2'b10;
        end else if (w_reg_write && (w_rd != 5'd0) && (w_rd == r_eRs2)) begin
            w_fwdB = 2'b01;
        end
    end
`else
    logic w_eProduces;
    logic w_rs1Hit;
    logic w_rs2Hit;
    logic w_unusedWb;

    // WB writes the register file in the first half-cycle, so its fields are never needed here
    assign w_unusedWb = ^{w_rd, w_reg_write};

    // Without forwarding, any pending producer in EX or MEM holds the dependent decode instruction
    always_comb begin
        w_eProduces = r_eValid && r_eRegWrite;
        w_rs1Hit    = (d_rs1 != 5'd0) &&
                      ((w_eProduces && (r_eRd == d_rs1)) || (m_reg_write && (m_rd == d_rs1)));
        w_rs2Hit    = (d_rs2 != 5'd0) &&
                      ((w_eProduces && (r_eRd == d_rs2)) || (m_reg_write && (m_rd == d_rs2)));
        w_hazardStall = w_rs1Hit || w_rs2Hit;
        w_fwdA        = 2'b00;
        w_fwdB        = 2'b00;
    end
`endif

    assign w_flushE = w_hazardStall || e_pc_src;

    // Hazard outputs: a redirect overrides a stall, and reset silences everything
    always_comb begin
        stall_f     = 1'b0;
        stall_d     = 1'b0;
        flush_d     = 1'b0;
        forward_a_e = 2'b00;
        forward_b_e = 2'b00;
        if (rst_n) begin
            stall_f     = w_hazardStall && !e_pc_src;
            stall_d     = w_hazardStall && !e_pc_src;
            flush_d     = e_pc_src;
            forward_a_e = w_fwdA;
            forward_b_e = w_fwdB;
        end
    end

    // ID/EX register: reset and bubble insertion both leave an all-zero, invalid EX slot
    always_ff @(posedge clk) begin
        if (!rst_n || w_flushE) begin
            r_eResultSrc  <= 2'b00;
            r_eMemWrite   <= 1'b0;
            r_eBranch     <= 1'b0;
            r_eAluSrc     <= 1'b0;
            r_eRegWrite   <= 1'b0;
            r_eJump       <= 1'b0;
            r_eAluControl <= 3'b000;
            r_eRd1        <= '0;
            r_eRd2        <= '0;
            r_ePc         <= '0;
            r_ePcPlus4    <= '0;
            r_eImmExt     <= '0;
            r_eRs1        <= 5'd0;
            r_eRs2        <= 5'd0;
            r_eRd         <= 5'd0;
            r_eValid      <= 1'b0;
        end else begin
            r_eResultSrc  <= d_result_src;
            r_eMemWrite   <= d_mem_write;
            r_eBranch     <= d_branch;
            r_eAluSrc     <= d_alu_src;
            r_eRegWrite   <= d_reg_write;
            r_eJump       <= d_jump;
            r_eAluControl <= d_alu_control;
            r_eRd1        <= d_rd1;
            r_eRd2        <= d_rd2;
            r_ePc         <= d_pc;
            r_ePcPlus4    <= d_pc_plus4;
            r_eImmExt     <= d_imm_ext;
            r_eRs1        <= d_rs1;
            r_eRs2        <= d_rs2;
            r_eRd         <= d_rd;
            r_eValid      <= 1'b1;
        end
    end

    assign e_result_src  = r_eResultSrc;
    assign e_mem_write   = r_eMemWrite;
    assign e_branch      = r_eBranch;
    assign e_alu_src     = r_eAluSrc;
    assign e_reg_write   = r_eRegWrite;
    assign e_jump        = r_eJump;
    assign e_alu_control = r_eAluControl;
    assign e_rd1         = r_eRd1;
    assign e_rd2         = r_eRd2;
    assign e_pc          = r_ePc;
    assign e_pc_plus4    = r_ePcPlus4;
    assign e_imm_ext     = r_eImmExt;
    assign e_rs1         = r_eRs1;
    assign e_rs2         = r_eRs2;
    assign e_rd          = r_eRd;
    assign e_valid       = r_eValid;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: self-checking bench for id_ex_stage.
// A reference model of the EX slot and the downstream MEM/WB destinations predicts
// the hazard outputs each cycle and queues the expected EX contents for the next edge.
// Builds with or without FORWARDING_EN; expectations follow the same macro.
module tb_id_ex_stage;

    localparam int XLEN = 32;

`ifdef FORWARDING_EN
    localparam int         LU_STALLS  = 1;
    localparam int         RAW_STALLS = 0;
    localparam logic [1:0] FWD_MEM    = 2'b10;
    localparam logic [1:0] FWD_WB     = 2'b01;
`else
    localparam int         LU_STALLS  = 2;
    localparam int         RAW_STALLS = 2;
    localparam logic [1:0] FWD_MEM    = 2'b00;
    localparam logic [1:0] FWD_WB     = 2'b00;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic [1:0]      d_result_src;
    logic            d_mem_write, d_branch, d_alu_src, d_reg_write, d_jump;
    logic [2:0]      d_alu_control;
    logic [XLEN-1:0] d_rd1, d_rd2, d_pc, d_pc_plus4, d_imm_ext;
    logic [4:0]      d_rs1, d_rs2, d_rd;
    logic            e_pc_src;
    logic [4:0]      m_rd, w_rd;
    logic            m_reg_write, w_reg_write;
    logic [1:0]      e_result_src;
    logic            e_mem_write, e_branch, e_alu_src, e_reg_write, e_jump;
    logic [2:0]      e_alu_control;
    logic [XLEN-1:0] e_rd1, e_rd2, e_pc, e_pc_plus4, e_imm_ext;
    logic [4:0]      e_rs1, e_rs2, e_rd;
    logic            e_valid, stall_f, stall_d, flush_d;
    logic [1:0]      forward_a_e, forward_b_e;

    typedef struct packed {
        logic        valid;
        logic [1:0]  resultSrc;
        logic        memWrite;
        logic        branch;
        logic        aluSrc;
        logic        regWrite;
        logic        jump;
        logic [2:0]  aluCtl;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] pc;
        logic [31:0] pcPlus4;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
    } exBundle_t;

    exBundle_t modelE;
    exBundle_t expQ[$];
    exBundle_t obsE;

    int   checks = 0;
    int   failures = 0;
    int   dutStallCycles = 0;
    logic lastStall;
    logic lastObsStallF, lastObsFlushD;
    logic forceMW;
    logic [4:0] pipeMRd, pipeWRd;
    logic pipeMWe, pipeWWe;

    id_ex_stage #(.XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n),
        .d_result_src(d_result_src), .d_mem_write(d_mem_write), .d_branch(d_branch),
        .d_alu_src(d_alu_src), .d_reg_write(d_reg_write), .d_jump(d_jump),
        .d_alu_control(d_alu_control), .d_rd1(d_rd1), .d_rd2(d_rd2), .d_pc(d_pc),
        .d_pc_plus4(d_pc_plus4), .d_imm_ext(d_imm_ext), .d_rs1(d_rs1), .d_rs2(d_rs2),
        .d_rd(d_rd), .e_pc_src(e_pc_src), .m_rd(m_rd), .w_rd(w_rd),
        .m_reg_write(m_reg_write), .w_reg_write(w_reg_write),
        .e_result_src(e_result_src), .e_mem_write(e_mem_write), .e_branch(e_branch),
        .e_alu_src(e_alu_src), .e_reg_write(e_reg_write), .e_jump(e_jump),
        .e_alu_control(e_alu_control), .e_rd1(e_rd1), .e_rd2(e_rd2), .e_pc(e_pc),
        .e_pc_plus4(e_pc_plus4), .e_imm_ext(e_imm_ext), .e_rs1(e_rs1), .e_rs2(e_rs2),
        .e_rd(e_rd), .e_valid(e_valid), .stall_f(stall_f), .stall_d(stall_d),
        .flush_d(flush_d), .forward_a_e(forward_a_e), .forward_b_e(forward_b_e)
    );

    // Free-running 10-unit clock
    always #5 clk = ~clk;

    assign obsE = {e_valid, e_result_src, e_mem_write, e_branch, e_alu_src, e_reg_write,
                   e_jump, e_alu_control, e_rd1, e_rd2, e_pc, e_pc_plus4, e_imm_ext,
                   e_rs1, e_rs2, e_rd};

    task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model of the decode stall for the current EX slot and MEM destination
    function automatic logic srcHit(input logic [4:0] r);
        return (r != 5'd0) &&
               ((modelE.valid && modelE.regWrite && modelE.rd == r) || (m_reg_write && m_rd == r));
    endfunction

    function automatic logic [1:0] fwdSel(input logic [4:0] r);
        if (m_reg_write && m_rd != 5'd0 && m_rd == r) return 2'b10;
        if (w_reg_write && w_rd != 5'd0 && w_rd == r) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic expStall();
        if (!rst_n) return 1'b0;
`ifdef FORWARDING_EN
        return modelE.valid && modelE.resultSrc == 2'b01 && modelE.rd != 5'd0 &&
               (modelE.rd == d_rs1 || modelE.rd == d_rs2);
`else
        return srcHit(d_rs1) || srcHit(d_rs2);
`endif
    endfunction

    function automatic logic [6:0] expHaz(input logic st);
        logic [1:0] fa, fb;
        if (!rst_n) return 7'd0;
`ifdef FORWARDING_EN
        fa = fwdSel(modelE.rs1);
        fb = fwdSel(modelE.rs2);
`else
        fa = 2'b00;
        fb = 2'b00;
`endif
        return {st && !e_pc_src, st && !e_pc_src, e_pc_src, fa, fb};
    endfunction

    task automatic drivePipe();
        if (!forceMW) begin
            m_rd = pipeMRd; m_reg_write = pipeMWe;
            w_rd = pipeWRd; w_reg_write = pipeWWe;
        end
    endtask

    task automatic applyStimulus(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                                 input logic [1:0] rsrc, input logic we, input logic mw,
                                 input logic [2:0] alu, input logic [31:0] pc, input logic pcSrc);
        d_rs1 = rs1; d_rs2 = rs2; d_rd = rd;
        d_result_src = rsrc; d_reg_write = we; d_mem_write = mw; d_alu_control = alu;
        d_branch = 1'($urandom_range(0, 1));
        d_alu_src = 1'($urandom_range(0, 1));
        d_jump = 1'($urandom_range(0, 1));
        d_pc = pc; d_pc_plus4 = pc + 32'd4;
        d_rd1 = pc ^ 32'h5A5A_0F0F; d_rd2 = ~pc; d_imm_ext = {pc[15:0], pc[31:16]};
        e_pc_src = pcSrc;
        drivePipe();
    endtask

    // One clock: check hazards mid-cycle, queue the predicted EX slot, compare it after the edge
    task automatic stepCycle(input string tag);
        logic st;
        logic newMWe;
        logic [4:0] newMRd;
        exBundle_t nxt;
        @(negedge clk);
        st = expStall();
        lastObsStallF = stall_f;
        lastObsFlushD = flush_d;
        if (stall_d === 1'b1) dutStallCycles++;
        checkOutput({tag, "_haz"}, {stall_f, stall_d, flush_d, forward_a_e, forward_b_e}, expHaz(st));
        nxt = '0;
        if (rst_n && !st && !e_pc_src) begin
            nxt.valid = 1'b1; nxt.resultSrc = d_result_src; nxt.memWrite = d_mem_write;
            nxt.branch = d_branch; nxt.aluSrc = d_alu_src; nxt.regWrite = d_reg_write;
            nxt.jump = d_jump; nxt.aluCtl = d_alu_control; nxt.rd1 = d_rd1; nxt.rd2 = d_rd2;
            nxt.pc = d_pc; nxt.pcPlus4 = d_pc_plus4; nxt.imm = d_imm_ext;
            nxt.rs1 = d_rs1; nxt.rs2 = d_rs2; nxt.rd = d_rd;
        end
        lastStall = rst_n && st && !e_pc_src;
        expQ.push_back(nxt);
        newMWe = rst_n && modelE.valid && modelE.regWrite;
        newMRd = rst_n ? modelE.rd : 5'd0;
        @(posedge clk);
        #1;
        modelE = expQ.pop_front();
        checkOutput({tag, "_ex"}, obsE, modelE);
        pipeWWe = rst_n && pipeMWe; pipeWRd = rst_n ? pipeMRd : 5'd0;
        pipeMWe = newMWe; pipeMRd = newMRd;
        drivePipe();
    endtask

    // Keep the current decode instruction presented until the model says it entered EX
    task automatic issue(input string tag);
        for (int k = 0; k < 4; k++) begin
            stepCycle(tag);
            if (!lastStall) break;
        end
    endtask

    initial begin
        modelE = '0;
        pipeMRd = 5'd0; pipeWRd = 5'd0; pipeMWe = 1'b0; pipeWWe = 1'b0;
        lastStall = 1'b0; lastObsStallF = 1'b0; lastObsFlushD = 1'b0;

        // Reset with every input at ones
        rst_n = 1'b0;
        forceMW = 1'b1;
        m_rd = 5'h1F; w_rd = 5'h1F; m_reg_write = 1'b1; w_reg_write = 1'b1;
        applyStimulus(5'h1F, 5'h1F, 5'h1F, 2'b11, 1'b1, 1'b1, 3'b111, 32'hFFFF_FFFF, 1'b1);
        d_branch = 1'b1; d_alu_src = 1'b1; d_jump = 1'b1;
        stepCycle("rst0");
        stepCycle("rst1");
        checkOutput("rst_valid", e_valid, 1'b0);
        checkOutput("rst_pc", e_pc, 32'h0);
        checkOutput("rst_haz", {stall_f, stall_d, flush_d, forward_a_e, forward_b_e}, 7'd0);
        rst_n = 1'b1;
        forceMW = 1'b0;
        drivePipe();

        // Pass-through
        applyStimulus(5'd1, 5'd2, 5'd10, 2'b00, 1'b1, 1'b0, 3'b010, 32'h100, 1'b0);
        stepCycle("pass");
        checkOutput("pass_pc", e_pc, 32'h100);
        checkOutput("pass_regwrite", e_reg_write, 1'b1);
        checkOutput("pass_alu", e_alu_control, 3'b010);
        checkOutput("pass_valid", e_valid, 1'b1);

        // Load-use: lw x5 then add x6, x5, x1
        applyStimulus(5'd2, 5'd0, 5'd5, 2'b01, 1'b1, 1'b0, 3'b000, 32'h104, 1'b0);
        issue("lw");
        dutStallCycles = 0;
        applyStimulus(5'd5, 5'd1, 5'd6, 2'b00, 1'b1, 1'b0, 3'b000, 32'h108, 1'b0);
        stepCycle("lu_first");
        checkOutput("lu_bubble_valid", e_valid, 1'b0);
        checkOutput("lu_bubble_regwrite", e_reg_write, 1'b0);
        issue("lu_add");
        checkOutput("lu_stall_cycles", dutStallCycles, LU_STALLS);
        checkOutput("lu_add_in_ex", {e_valid, e_rd}, {1'b1, 5'd6});
        applyStimulus(5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 3'b000, 32'h10C, 1'b0);
        #2;
        checkOutput("lu_fwd_a", forward_a_e, FWD_WB);

        // Forwarding priority on both operands
        applyStimulus(5'd7, 5'd3, 5'd0, 2'b00, 1'b0, 1'b0, 3'b001, 32'h110, 1'b0);
        issue("fwd_setup");
        forceMW = 1'b1;
        d_rs1 = 5'd0; d_rs2 = 5'd0;
        m_rd = 5'd7; m_reg_write = 1'b1; w_rd = 5'd7; w_reg_write = 1'b1;
        #2;
        checkOutput("fwd_a_mem_over_wb", forward_a_e, FWD_MEM);
        w_rd = 5'd3;
        #1;
        checkOutput("fwd_b_wb", forward_b_e, FWD_WB);
        m_rd = 5'd0; w_rd = 5'd0;
        #1;
        checkOutput("fwd_x0", {forward_a_e, forward_b_e}, 4'b0000);
        forceMW = 1'b0;
        drivePipe();

        // Redirect after a store
        applyStimulus(5'd1, 5'd2, 5'd0, 2'b00, 1'b0, 1'b1, 3'b000, 32'h200, 1'b0);
        issue("store");
        applyStimulus(5'd4, 5'd5, 5'd8, 2'b00, 1'b1, 1'b0, 3'b000, 32'h204, 1'b1);
        stepCycle("redir");
        checkOutput("redir_flush_d", lastObsFlushD, 1'b1);
        checkOutput("redir_bubble", {e_valid, e_mem_write}, 2'b00);

        // Redirect coinciding with a load-use stall
        applyStimulus(5'd1, 5'd0, 5'd9, 2'b01, 1'b1, 1'b0, 3'b000, 32'h300, 1'b0);
        issue("lw9");
        applyStimulus(5'd9, 5'd0, 5'd11, 2'b00, 1'b1, 1'b0, 3'b000, 32'h304, 1'b1);
        stepCycle("redir_lw");
        checkOutput("redir_lw_stall_f", lastObsStallF, 1'b0);
        checkOutput("redir_lw_flush_d", lastObsFlushD, 1'b1);
        checkOutput("redir_lw_bubble", e_valid, 1'b0);

        // RAW dependence on a non-load: add x3, then sub x4, x3, x2
        applyStimulus(5'd1, 5'd2, 5'd3, 2'b00, 1'b1, 1'b0, 3'b000, 32'h400, 1'b0);
        issue("raw_add");
        dutStallCycles = 0;
        applyStimulus(5'd3, 5'd2, 5'd4, 2'b00, 1'b1, 1'b0, 3'b001, 32'h404, 1'b0);
        issue("raw_sub");
        checkOutput("raw_stall_cycles", dutStallCycles, RAW_STALLS);
        checkOutput("raw_sub_in_ex", {e_valid, e_rs1, e_rd}, {1'b1, 5'd3, 5'd4});

        // Reset in the middle of a stall drops it immediately
        applyStimulus(5'd1, 5'd0, 5'd5, 2'b01, 1'b1, 1'b0, 3'b000, 32'h500, 1'b0);
        issue("mid_lw");
        applyStimulus(5'd5, 5'd0, 5'd6, 2'b00, 1'b1, 1'b0, 3'b000, 32'h504, 1'b0);
        #2;
        checkOutput("mid_stall_before", stall_d, 1'b1);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_stall_dropped", {stall_f, stall_d}, 2'b00);
        stepCycle("mid_rst");
        rst_n = 1'b1;
        issue("mid_readd");

        // Random traffic over a small register window
        for (int i = 0; i < 24; i++) begin
            applyStimulus(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                          2'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          3'($urandom_range(0, 7)), $urandom, ($urandom_range(0, 7) == 0));
            stepCycle("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
